// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader -- UART program loader and registered instruction-fetch port
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int CLK_HZ   = 27_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 2048,
  parameter bit AUTO_RUN = 1'b1,
  localparam int c_AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  input  logic [c_AW-1:0] pc,
  output logic [15:0]     dout,
  output logic            cpu_rst_n,
  output logic            loading,
  output logic            err,
  output logic [11:0]     prog_len
);

  localparam int c_CPB = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_CW  = $clog2(c_CPB);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(c_CPB - 1);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(c_CPB / 2 - 1);

  localparam logic [1:0] c_RX_IDLE  = 2'd0;
  localparam logic [1:0] c_RX_START = 2'd1;
  localparam logic [1:0] c_RX_DATA  = 2'd2;
  localparam logic [1:0] c_RX_STOP  = 2'd3;

  localparam logic [2:0] c_F_IDLE    = 3'd0;
  localparam logic [2:0] c_F_LEN_H   = 3'd1;
  localparam logic [2:0] c_F_LEN_L   = 3'd2;
  localparam logic [2:0] c_F_DATA_LO = 3'd3;
  localparam logic [2:0] c_F_DATA_HI = 3'd4;
  localparam logic [2:0] c_F_CSUM    = 3'd5;
  localparam logic [2:0] c_F_RUN     = 3'd6;

  localparam logic [7:0]  c_SYNC_BYTE = 8'hA5;
  localparam logic [11:0] c_DEPTH12   = 12'(DEPTH);

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  logic            r_rx_s1;
  logic            r_rx_s2;
  logic            r_rx_d;
  logic [1:0]      r_rx_state;
  logic [1:0]      w_rx_state_nxt;
  logic [c_CW-1:0] r_bit_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_rx_byte;
  logic            r_rx_valid;
  logic            r_rx_ferr;
  logic            w_tick;
  logic            w_fall;

  assign w_tick = (r_bit_cnt == '0);
  assign w_fall = r_rx_d & ~r_rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= c_RX_IDLE;
    end else begin
      r_rx_state <= w_rx_state_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      c_RX_IDLE:  if (w_fall) w_rx_state_nxt = c_RX_START;
      c_RX_START: if (w_tick) w_rx_state_nxt = r_rx_s2 ? c_RX_IDLE : c_RX_DATA;
      c_RX_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_rx_state_nxt = c_RX_STOP;
      c_RX_STOP:  if (w_tick) w_rx_state_nxt = c_RX_IDLE;
      default:    w_rx_state_nxt = c_RX_IDLE;
    endcase
  end

  // Idle keeps the counter primed so the start bit is re-checked half a bit in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= c_HALF;
      r_bit_idx  <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        c_RX_IDLE: begin
          r_bit_cnt <= c_HALF;
        end
        c_RX_START: begin
          if (w_tick) begin
            r_bit_cnt <= c_FULL;
            r_bit_idx <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        c_RX_DATA: begin
          if (w_tick) begin
            r_bit_cnt <= c_FULL;
            r_bit_idx <= r_bit_idx + 1'b1;
            r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        c_RX_STOP: begin
          if (w_tick) begin
            r_rx_valid <= r_rx_s2;
            r_rx_ferr  <= ~r_rx_s2;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        default: r_bit_cnt <= c_HALF;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  logic [2:0]  r_fstate;
  logic [2:0]  w_fstate_nxt;
  logic [3:0]  r_len_h;
  logic [11:0] r_len;
  logic [11:0] r_waddr;
  logic [7:0]  r_lo;
  logic [7:0]  r_sum;
  logic        r_cpu_rst_n;
  logic        r_loading;
  logic        r_err;
  logic [11:0] r_prog_len;

  logic [11:0] w_len_rx;
  logic        w_is_sync;
  logic        w_len_bad;
  logic        w_last_word;
  logic        w_csum_ok;
  logic        w_ram_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fstate <= AUTO_RUN ? c_F_RUN : c_F_IDLE;
    end else begin
      r_fstate <= w_fstate_nxt;
    end
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    if (r_rx_ferr) begin
      w_fstate_nxt = c_F_IDLE;
    end else if (r_rx_valid) begin
      case (r_fstate)
        c_F_IDLE, c_F_RUN: if (w_is_sync) w_fstate_nxt = c_F_LEN_H;
        c_F_LEN_H:         w_fstate_nxt = c_F_LEN_L;
        c_F_LEN_L:         w_fstate_nxt = w_len_bad ? c_F_IDLE : c_F_DATA_LO;
        c_F_DATA_LO:       w_fstate_nxt = c_F_DATA_HI;
        c_F_DATA_HI:       w_fstate_nxt = w_last_word ? c_F_CSUM : c_F_DATA_LO;
        c_F_CSUM:          w_fstate_nxt = w_csum_ok ? c_F_RUN : c_F_IDLE;
        default:           w_fstate_nxt = c_F_IDLE;
      endcase
    end
  end

  always_comb begin
    w_len_rx    = {r_len_h, r_rx_byte};
    w_is_sync   = (r_rx_byte == c_SYNC_BYTE);
    w_len_bad   = (w_len_rx == 12'd0) || (w_len_rx > c_DEPTH12);
    w_last_word = ((r_waddr + 12'd1) == r_len);
    w_csum_ok   = (r_rx_byte == r_sum);
    w_ram_we    = r_rx_valid && (r_fstate == c_F_DATA_HI) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rst_n <= AUTO_RUN;
      r_loading   <= 1'b0;
      r_err       <= 1'b0;
      r_prog_len  <= AUTO_RUN ? c_DEPTH12 : 12'd0;
      r_len_h     <= '0;
      r_len       <= '0;
      r_waddr     <= '0;
      r_lo        <= '0;
      r_sum       <= '0;
    end else if (r_rx_ferr) begin
      r_err     <= 1'b1;
      r_loading <= 1'b0;
    end else if (r_rx_valid) begin
      case (r_fstate)
        c_F_IDLE, c_F_RUN: begin
          if (w_is_sync) begin
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_loading   <= 1'b1;
            r_waddr     <= '0;
            r_sum       <= '0;
          end
        end
        c_F_LEN_H: r_len_h <= r_rx_byte[3:0];
        c_F_LEN_L: begin
          r_len <= w_len_rx;
          if (w_len_bad) begin
            r_err     <= 1'b1;
            r_loading <= 1'b0;
          end
        end
        c_F_DATA_LO: begin
          r_lo  <= r_rx_byte;
          r_sum <= r_sum + r_rx_byte;
        end
        c_F_DATA_HI: begin
          r_sum   <= r_sum + r_rx_byte;
          r_waddr <= r_waddr + 12'd1;
        end
        c_F_CSUM: begin
          r_loading <= 1'b0;
          if (w_csum_ok) begin
            r_prog_len  <= r_len;
            r_cpu_rst_n <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_loading <= 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Instruction RAM and fetch port
  // --------------------------------------------------------------------------
  logic [15:0] r_ram [DEPTH];
  logic [15:0] r_dout;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[r_waddr[c_AW-1:0]] <= {r_rx_byte, r_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else begin
      r_dout <= r_ram[pc];
    end
  end

  assign dout      = r_cpu_rst_n ? r_dout : 16'h0000;
  assign cpu_rst_n = r_cpu_rst_n;
  assign loading   = r_loading;
  assign err       = r_err;
  assign prog_len  = r_prog_len;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader -- randomized frame-level checks of prog_loader
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int CPB    = 16;
  localparam int DEPTH  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic [10:0] pc;
  logic [15:0] dout;
  logic        cpu_rst_n;
  logic        loading;
  logic        err;
  logic [11:0] prog_len;

  always #5 clk = ~clk;

  prog_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .AUTO_RUN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .pc(pc), .dout(dout),
    .cpu_rst_n(cpu_rst_n), .loading(loading), .err(err), .prog_len(prog_len)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: program image plus the externally visible loader status.
  logic [15:0] m_ram [DEPTH];
  bit          m_run;
  bit          m_err;
  bit          m_loading;
  logic [11:0] m_len;

  task automatic send_byte(input logic [7:0] b, input bit bad_stop,
                           output logic early, output logic late);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = ~bad_stop;
    repeat (4) @(negedge clk);
    early = cpu_rst_n;
    repeat (CPB - 4) @(negedge clk);
    late = cpu_rst_n;
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_glitch();
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic fetch(input logic [10:0] a, output logic [15:0] d);
    pc = a;
    @(negedge clk);
    d = dout;
  endtask

  // Sends a whole frame and applies its effect to the model.
  task automatic send_frame(input logic [15:0] w[$], input logic [11:0] len,
                            input logic [3:0] nib, input bit bad_csum,
                            input int glitch_at, output logic early,
                            output logic late);
    logic [7:0] b[$];
    logic [7:0] sum;
    bit         len_ok;
    sum    = 8'd0;
    len_ok = (len != 12'd0) && (len <= 12'(DEPTH));
    b.push_back(8'hA5);
    b.push_back({nib, len[11:8]});
    b.push_back(len[7:0]);
    if (len_ok) begin
      foreach (w[i]) begin
        b.push_back(w[i][7:0]);
        b.push_back(w[i][15:8]);
        sum = sum + w[i][7:0] + w[i][15:8];
      end
      b.push_back(bad_csum ? sum + 8'd1 : sum);
    end
    foreach (b[i]) begin
      if (i == glitch_at) send_glitch();
      send_byte(b[i], 1'b0, early, late);
    end
    m_loading = 1'b0;
    if (!len_ok) begin
      m_err = 1'b1;
      m_run = 1'b0;
    end else begin
      foreach (w[i]) m_ram[i] = w[i];
      if (bad_csum) begin
        m_err = 1'b1;
        m_run = 1'b0;
      end else begin
        m_err = 1'b0;
        m_run = 1'b1;
        m_len = len;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    m_run = 1'b1; m_err = 1'b0; m_loading = 1'b0; m_len = 12'(DEPTH);
    total++; if (cpu_rst_n !== m_run) begin bad++; $display("FAIL rst_cpu_rst_n: got %0b want %0b", cpu_rst_n, m_run); end
    total++; if (err !== m_err) begin bad++; $display("FAIL rst_err: got %0b want %0b", err, m_err); end
    total++; if (loading !== m_loading) begin bad++; $display("FAIL rst_loading: got %0b want %0b", loading, m_loading); end
    total++; if (prog_len !== m_len) begin bad++; $display("FAIL rst_prog_len: got %0d want %0d", prog_len, m_len); end
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL rst_dout: got %h want 0000", dout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    logic [15:0] q[$];
    logic [15:0] d;
    logic e, l;
    q = {16'h1234, 16'hABCD};
    send_frame(q, 12'd2, 4'h0, 1'b0, -1, e, l);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_release_early: got %0b want 0", e); end
    total++; if (l !== 1'b1) begin bad++; $display("FAIL basic_release_late: got %0b want 1", l); end
    total++; if (err !== m_err) begin bad++; $display("FAIL basic_err: got %0b want %0b", err, m_err); end
    total++; if (prog_len !== 12'd2) begin bad++; $display("FAIL basic_prog_len: got %0d want 2", prog_len); end
    total++; if (loading !== 1'b0) begin bad++; $display("FAIL basic_loading: got %0b want 0", loading); end
    fetch(11'd1, d);
    total++; if (d !== 16'hABCD) begin bad++; $display("FAIL basic_fetch1: got %h want abcd", d); end
    fetch(11'd0, d);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL basic_fetch0: got %h want 1234", d); end
  endtask

  task automatic test_bad_csum();
    logic [15:0] q[$];
    logic [15:0] d, w;
    logic [7:0]  cs;
    logic e, l;
    q = {16'($urandom), 16'($urandom)};
    send_frame(q, 12'd2, 4'h0, 1'b1, -1, e, l);
    total++; if (err !== m_err) begin bad++; $display("FAIL csum_err: got %0b want %0b", err, m_err); end
    total++; if (cpu_rst_n !== m_run) begin bad++; $display("FAIL csum_cpu_rst_n: got %0b want %0b", cpu_rst_n, m_run); end
    total++; if (loading !== 1'b0) begin bad++; $display("FAIL csum_loading: got %0b want 0", loading); end
    fetch(11'd0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL csum_dout_held: got %h want 0000", d); end
    send_byte(8'h12, 1'b0, e, l);
    send_byte(8'h00, 1'b0, e, l);
    total++; if (err !== 1'b1 || loading !== 1'b0) begin bad++; $display("FAIL stray_bytes: got err=%0b loading=%0b want err=1 loading=0", err, loading); end
    send_byte(8'hA5, 1'b0, e, l);
    m_err = 1'b0; m_loading = 1'b1; m_run = 1'b0;
    total++; if (err !== m_err) begin bad++; $display("FAIL resync_err_clear: got %0b want %0b", err, m_err); end
    total++; if (loading !== m_loading) begin bad++; $display("FAIL resync_loading: got %0b want %0b", loading, m_loading); end
    w  = 16'($urandom);
    cs = w[7:0] + w[15:8];
    send_byte(8'h00, 1'b0, e, l);
    send_byte(8'h01, 1'b0, e, l);
    send_byte(w[7:0], 1'b0, e, l);
    send_byte(w[15:8], 1'b0, e, l);
    send_byte(cs, 1'b0, e, l);
    m_ram[0] = w; m_run = 1'b1; m_err = 1'b0; m_loading = 1'b0; m_len = 12'd1;
    total++; if (l !== 1'b1 || prog_len !== m_len) begin bad++; $display("FAIL resync_load: got rel=%0b len=%0d want rel=1 len=%0d", l, prog_len, m_len); end
    fetch(11'd0, d);
    total++; if (d !== m_ram[0]) begin bad++; $display("FAIL resync_fetch: got %h want %h", d, m_ram[0]); end
  endtask

  task automatic test_len_errors();
    logic [15:0] q[$];
    logic [15:0] none[$];
    logic [15:0] d;
    logic e, l;
    send_frame(none, 12'h000, 4'h0, 1'b0, -1, e, l);
    total++; if (err !== m_err || loading !== 1'b0) begin bad++; $display("FAIL len0: got err=%0b loading=%0b want err=%0b loading=0", err, loading, m_err); end
    total++; if (cpu_rst_n !== m_run) begin bad++; $display("FAIL len0_cpu_rst_n: got %0b want %0b", cpu_rst_n, m_run); end
    send_frame(none, 12'h801, 4'h0, 1'b0, -1, e, l);
    total++; if (err !== m_err || loading !== 1'b0) begin bad++; $display("FAIL len801: got err=%0b loading=%0b want err=%0b loading=0", err, loading, m_err); end
    q = {16'($urandom), 16'($urandom)};
    send_frame(q, 12'd2, 4'hF, 1'b0, -1, e, l);
    total++; if (err !== m_err || prog_len !== m_len) begin bad++; $display("FAIL len_nibble: got err=%0b len=%0d want err=%0b len=%0d", err, prog_len, m_err, m_len); end
    fetch(11'd1, d);
    total++; if (d !== m_ram[1]) begin bad++; $display("FAIL len_nibble_fetch: got %h want %h", d, m_ram[1]); end
  endtask

  task automatic test_framing_error();
    logic [15:0] d;
    logic e, l;
    send_byte(8'h5C, 1'b1, e, l);
    m_err = 1'b1;
    total++; if (err !== m_err) begin bad++; $display("FAIL ferr_run_err: got %0b want %0b", err, m_err); end
    total++; if (cpu_rst_n !== m_run) begin bad++; $display("FAIL ferr_run_cpu: got %0b want %0b", cpu_rst_n, m_run); end
    fetch(11'd0, d);
    total++; if (d !== m_ram[0]) begin bad++; $display("FAIL ferr_run_fetch: got %h want %h", d, m_ram[0]); end
    send_byte(8'hA5, 1'b0, e, l);
    send_byte(8'h00, 1'b0, e, l);
    send_byte(8'h02, 1'b0, e, l);
    send_byte(8'($urandom), 1'b0, e, l);
    send_byte(8'($urandom), 1'b1, e, l);
    m_err = 1'b1; m_run = 1'b0; m_loading = 1'b0;
    total++; if (err !== m_err || loading !== m_loading) begin bad++; $display("FAIL ferr_frame: got err=%0b loading=%0b want err=1 loading=0", err, loading); end
    total++; if (cpu_rst_n !== m_run) begin bad++; $display("FAIL ferr_frame_cpu: got %0b want %0b", cpu_rst_n, m_run); end
  endtask

  task automatic test_glitch();
    logic [15:0] q[$];
    logic [15:0] d;
    logic e, l;
    send_glitch();
    total++; if (err !== m_err || loading !== 1'b0) begin bad++; $display("FAIL glitch_idle: got err=%0b loading=%0b want err=%0b loading=0", err, loading, m_err); end
    q = {16'($urandom)};
    send_frame(q, 12'd1, 4'h0, 1'b0, 3, e, l);
    total++; if (err !== m_err || cpu_rst_n !== m_run || prog_len !== m_len) begin bad++; $display("FAIL glitch_frame: got err=%0b run=%0b len=%0d want err=%0b run=%0b len=%0d", err, cpu_rst_n, prog_len, m_err, m_run, m_len); end
    fetch(11'd0, d);
    total++; if (d !== m_ram[0]) begin bad++; $display("FAIL glitch_fetch: got %h want %h", d, m_ram[0]); end
  endtask

  task automatic test_rst_midframe();
    logic [15:0] q[$];
    logic [15:0] d;
    logic e, l;
    q = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    send_byte(8'hA5, 1'b0, e, l);
    send_byte(8'h00, 1'b0, e, l);
    send_byte(8'h04, 1'b0, e, l);
    send_byte(q[0][7:0], 1'b0, e, l);
    send_byte(q[0][15:8], 1'b0, e, l);
    send_byte(q[1][7:0], 1'b0, e, l);
    m_ram[0] = q[0];
    rst = 1'b1;
    @(negedge clk);
    m_run = 1'b1; m_err = 1'b0; m_loading = 1'b0; m_len = 12'(DEPTH);
    total++; if (cpu_rst_n !== m_run || loading !== m_loading || err !== m_err) begin bad++; $display("FAIL midrst_flags: got run=%0b loading=%0b err=%0b want 1 0 0", cpu_rst_n, loading, err); end
    total++; if (prog_len !== m_len) begin bad++; $display("FAIL midrst_prog_len: got %0d want %0d", prog_len, m_len); end
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL midrst_dout: got %h want 0000", dout); end
    rst = 1'b0;
    @(negedge clk);
    fetch(11'd0, d);
    total++; if (d !== m_ram[0]) begin bad++; $display("FAIL midrst_partial_word: got %h want %h", d, m_ram[0]); end
    q = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    send_frame(q, 12'd4, 4'h0, 1'b0, -1, e, l);
    total++; if (e !== 1'b0 || l !== 1'b1 || prog_len !== m_len) begin bad++; $display("FAIL midrst_reload: got rel=%0b%0b len=%0d want rel=01 len=%0d", e, l, prog_len, m_len); end
    for (int i = 0; i < 4; i++) begin
      fetch(11'(i), d);
      total++; if (d !== m_ram[i]) begin bad++; $display("FAIL midrst_fetch[%0d]: got %h want %h", i, d, m_ram[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] d, exp_d;
    logic [10:0] a;
    logic        e, l;
    int          n;
    bit          bc;
    for (int k = 0; k < 4; k++) begin
      n  = int'($urandom_range(1, 5));
      bc = ($urandom_range(0, 3) == 0);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(16'($urandom));
      send_frame(q, 12'(n), 4'($urandom), bc, -1, e, l);
      total++; if (err !== m_err || cpu_rst_n !== m_run) begin bad++; $display("FAIL rand%0d_flags: got err=%0b run=%0b want err=%0b run=%0b", k, err, cpu_rst_n, m_err, m_run); end
      total++; if (prog_len !== m_len || loading !== 1'b0) begin bad++; $display("FAIL rand%0d_len: got len=%0d loading=%0b want len=%0d loading=0", k, prog_len, loading, m_len); end
      for (int j = 0; j < 3; j++) begin
        a     = 11'($urandom_range(0, n - 1));
        exp_d = m_run ? m_ram[a] : 16'h0000;
        fetch(a, d);
        total++; if (d !== exp_d) begin bad++; $display("FAIL rand%0d_fetch@%0d: got %h want %h", k, a, d, exp_d); end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    pc      = '0;
    test_reset();
    test_load_basic();
    test_bad_csum();
    test_len_errors();
    test_framing_error();
    test_glitch();
    test_rst_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
